vga_framebuffer_arbiter: RTL and testbench
==========================================

# vga_framebuffer_arbiter

- Shares one single-port synchronous framebuffer RAM between VGA scanout (read) and a pixel writer such as game logic or a drawing engine (write).
- Sits between the sync pulse generator (consumes its counts and sync pulses) and the DAC/pin drivers.
- Scanout always wins its slot; the writer fills every remaining cycle.
- Emits pixel data and sync pulses re-aligned to a fixed 3-cycle latency.

## Interface
Parameters:
- ACTIVE_COLS, 640, visible columns
- ACTIVE_ROWS, 480, visible rows
- SCALE_SHIFT, 2, log2 of pixel replication (stored pixel = 4x4 screen pixels)
- DATA_W, 12, colour width (RGB444)
- ADDR_W, 15, framebuffer address width

Ports:
- clock  in  1  pixel clock, 25 MHz
- reset  in  1  synchronous, active-high
- column_count  in  10  current column from the sync generator
- row_count  in  10  current row from the sync generator
- in_Hsync  in  1  Hsync from the sync generator
- in_Vsync  in  1  Vsync from the sync generator
- wr_valid  in  1  writer has a pixel
- wr_ready  out  1  arbiter accepts the pixel this cycle
- wr_addr  in  ADDR_W  framebuffer address of the pixel
- wr_data  in  DATA_W  pixel colour
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en with mem_we=0
- out_Hsync  out  1  in_Hsync delayed 3 cycles
- out_Vsync  out  1  in_Vsync delayed 3 cycles
- pix_data  out  DATA_W  colour aligned with out_Hsync/out_Vsync
- wr_oor  out  1  sticky out-of-range write flag (macro-dependent)

## Operation
- Framebuffer geometry:
  - FB_COLS = ACTIVE_COLS>>SCALE_SHIFT = 160
  - FB_ROWS = ACTIVE_ROWS>>SCALE_SHIFT = 120
  - FB_SIZE = FB_COLS*FB_ROWS = 19200
  - Linear address = y*FB_COLS + x
- Active = column_count<ACTIVE_COLS && row_count<ACTIVE_ROWS.
- Scanout slot = active && column_count[SCALE_SHIFT-1:0]==0. One slot every 4 cycles per active line.
- Scanout address = (row_count>>SCALE_SHIFT)*FB_COLS + (column_count>>SCALE_SHIFT). This is a constant multiply and must be computed in ADDR_W bits without overflow.
- Arbitration is combinational on the counts: wr_ready = !scanout_slot && !reset.
- Transfer occurs when wr_valid && wr_ready. The writer must hold wr_addr/wr_data stable until ready is seen.
- RAM command registers:
  - Scanout slot: mem_en=1, mem_we=0, mem_addr=scanout address.
  - Transfer: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - Otherwise: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their previous values.
- Pixel register:
  - Loads mem_rdata in the cycle after a scanout read.
  - Holds for the 4 cycles of that stored pixel.
  - Forced to 0 when the delayed active flag is 0, so pix_data=0 in blanking.
- Writer starvation bound: at most 1 consecutive not-ready cycle in active area; never stalled in blanking.
- Write/read to the same address in adjacent cycles: RAM order applies, no forwarding. The display may show the old value for one frame.

## Timing
- Count sample at cycle t, scanout slot:
  - t+1: mem_en/mem_addr visible
  - t+2: mem_rdata valid
  - t+3: pix_data visible, held through t+6
- out_Hsync/out_Vsync/active delay = exactly 3 registers, so sync stays aligned with pix_data.
- Write accepted at t: mem_we=1 at t+1 for exactly one cycle per transfer.
- Reset values (apply on reset-cycle edge, mid-frame included):
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
  - pix_data=0, out_Hsync=0, out_Vsync=0, wr_oor=0
  - delay lines cleared
- Counts wrap (799->0, 524->0) without any special case. Only active/slot decode uses them.

## Configuration
- VGA_FB_BOUNDS_CHECK_EN defined:
  - A transfer with wr_addr>=FB_SIZE is accepted (ready as normal) but issues no RAM command.
  - wr_oor sets and stays 1 until reset.
- Not defined:
  - All transfers are written with wr_addr unmodified.
  - wr_oor is tied 0.

## Structure
- Package vga_pkg holds:
  - timing constants (TOTAL_COLS 800, TOTAL_ROWS 525, ACTIVE_COLS, ACTIVE_ROWS)
  - SCALE_SHIFT, FB_COLS, FB_ROWS, FB_SIZE
  - pixel_t (DATA_W colour type)
- Sub-module vga_delay_line:
  - parameterised width and depth shift register with synchronous clear
  - used for the sync/active 3-stage alignment

## Test plan
- Reset mid-line at column 200 -> next cycle all outputs 0. After release, first scanout read at the next column with [1:0]==0.
- Free-running counts, wr_valid=0, RAM preloaded addr=value -> at row 4 col 8, mem_addr=162 at t+1 and pix_data=RAM[162] for cycles t+3..t+6.
- wr_valid held high through an active line:
  - wr_ready low only at columns 0,4,...,636; 480 writes per line
  - mem_we never high in the same cycle as a read
- Write addr 0 data 0xF00 during vblank (row 500) -> accepted immediately; next frame pix_data=0xF00 at rows 0-3, cols 0-3 (+3 latency).
- Sync alignment: in_Hsync falls at column 639 -> out_Hsync falls at column 642. pix_data=0 from column 643 on.
- With VGA_FB_BOUNDS_CHECK_EN, write addr 19200 -> mem_en stays 0, wr_oor=1 and sticky. Without the macro -> mem_we=1, mem_addr=19200, wr_oor=0.

Source files
------------

// File: rtl/vga_pkg.sv
// VGA timing constants and framebuffer geometry shared by the arbiter slice.
package vga_pkg;

  localparam int unsigned TOTAL_COLS  = 800;
  localparam int unsigned TOTAL_ROWS  = 525;
  localparam int unsigned ACTIVE_COLS = 640;
  localparam int unsigned ACTIVE_ROWS = 480;
  localparam int unsigned COUNT_W     = $clog2((TOTAL_COLS > TOTAL_ROWS) ? TOTAL_COLS : TOTAL_ROWS);

  localparam int unsigned SCALE_SHIFT = 2;
  localparam int unsigned FB_COLS     = ACTIVE_COLS >> SCALE_SHIFT;
  localparam int unsigned FB_ROWS     = ACTIVE_ROWS >> SCALE_SHIFT;
  localparam int unsigned FB_SIZE     = FB_COLS * FB_ROWS;

  localparam int unsigned DATA_W      = 12;
  localparam int unsigned ADDR_W      = 15;

  typedef logic [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/vga_framebuffer_arbiter_if.sv
// Writer handshake plus single-port framebuffer RAM bus; slave is the arbiter view.
interface vga_framebuffer_arbiter_if #(
  parameter int unsigned DATA_W = vga_pkg::DATA_W,
  parameter int unsigned ADDR_W = vga_pkg::ADDR_W
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous clear, for pipeline realignment.
module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_d, stage_q;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = din;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_framebuffer_arbiter.sv
// Shares one framebuffer RAM between scanout reads (fixed slots) and a pixel writer,
// re-aligning pixel data and syncs to a 3-cycle latency. Option: VGA_FB_BOUNDS_CHECK_EN.
module vga_framebuffer_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE_COLS = vga_pkg::ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS = vga_pkg::ACTIVE_ROWS,
  parameter int unsigned SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
  parameter int unsigned DATA_W      = vga_pkg::DATA_W,
  parameter int unsigned ADDR_W      = vga_pkg::ADDR_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [COUNT_W-1:0]  column_count,
  input  logic [COUNT_W-1:0]  row_count,
  input  logic                in_Hsync,
  input  logic                in_Vsync,
  vga_framebuffer_arbiter_if.slave fb,
  output logic                out_Hsync,
  output logic                out_Vsync,
  output logic [DATA_W-1:0]   pix_data,
  output logic                wr_oor
);

  localparam int unsigned        FB_COLS_L = ACTIVE_COLS >> SCALE_SHIFT;
  localparam logic [COUNT_W-1:0] COLS_C    = COUNT_W'(ACTIVE_COLS);
  localparam logic [COUNT_W-1:0] ROWS_C    = COUNT_W'(ACTIVE_ROWS);
  localparam logic [COUNT_W-1:0] SUB_MASK  = COUNT_W'((1 << SCALE_SHIFT) - 1);

  logic              active, slot, ready, xfer, addr_oor;
  logic [ADDR_W-1:0] scan_addr;

  // Arbitration is purely a decode of the current counts.
  always_comb begin
    active    = (column_count < COLS_C) && (row_count < ROWS_C);
    slot      = active && ((column_count & SUB_MASK) == '0);
    scan_addr = ADDR_W'(row_count >> SCALE_SHIFT) * ADDR_W'(FB_COLS_L)
              + ADDR_W'(column_count >> SCALE_SHIFT);
    ready     = !slot && !reset;
    xfer      = fb.wr_valid && ready;
  end

  assign fb.wr_ready = ready;

`ifdef VGA_FB_BOUNDS_CHECK_EN
  localparam int unsigned FB_SIZE_L = FB_COLS_L * (ACTIVE_ROWS >> SCALE_SHIFT);

  logic wr_oor_d, wr_oor_q;

  assign addr_oor = 32'(fb.wr_addr) >= FB_SIZE_L;
  assign wr_oor_d = wr_oor_q || (xfer && addr_oor);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_oor_q <= 1'b0;
    end else begin
      wr_oor_q <= wr_oor_d;
    end
  end

  assign wr_oor = wr_oor_q;
`else
  assign addr_oor = 1'b0;
  assign wr_oor   = 1'b0;
`endif

  logic              mem_en_d, mem_en_q, mem_we_d, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;

  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (slot) begin
      mem_en_d   = 1'b1;
      mem_addr_d = scan_addr;
    end else if (xfer && !addr_oor) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = fb.wr_addr;
      mem_wdata_d = fb.wr_data;
    end
  end

  // Active and slot flags ride two stages; the pixel register is the third.
  logic active_d2, slot_d2;

  vga_delay_line #(.WIDTH(2), .DEPTH(3)) u_sync_dly (
    .clock (clock),
    .clear (reset),
    .din   ({in_Hsync, in_Vsync}),
    .dout  ({out_Hsync, out_Vsync})
  );

  vga_delay_line #(.WIDTH(2), .DEPTH(2)) u_rd_dly (
    .clock (clock),
    .clear (reset),
    .din   ({active, slot}),
    .dout  ({active_d2, slot_d2})
  );

  logic [DATA_W-1:0] pix_d, pix_q;

  always_comb begin
    pix_d = pix_q;
    if (!active_d2) begin
      pix_d = '0;
    end else if (slot_d2) begin
      pix_d = fb.mem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pix_q       <= '0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pix_q       <= pix_d;
    end
  end

  assign fb.mem_en    = mem_en_q;
  assign fb.mem_we    = mem_we_q;
  assign fb.mem_addr  = mem_addr_q;
  assign fb.mem_wdata = mem_wdata_q;
  assign pix_data     = pix_q;

endmodule

// File: tb/tb_vga_framebuffer_arbiter.sv
// Directed bench for vga_framebuffer_arbiter with a framebuffer-level reference model.
module tb_vga_framebuffer_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  col, row;
  logic        hs, vs;
  logic        out_hs, out_vs, wr_oor;
  logic [11:0] pix;

  vga_framebuffer_arbiter_if #(.DATA_W(12), .ADDR_W(15)) fb ();

  vga_framebuffer_arbiter #(
    .ACTIVE_COLS (640),
    .ACTIVE_ROWS (480),
    .SCALE_SHIFT (2),
    .DATA_W      (12),
    .ADDR_W      (15)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .column_count (col),
    .row_count    (row),
    .in_Hsync     (hs),
    .in_Vsync     (vs),
    .fb           (fb),
    .out_Hsync    (out_hs),
    .out_Vsync    (out_vs),
    .pix_data     (pix),
    .wr_oor       (wr_oor)
  );

  always #5 clock = ~clock;

  assign hs = (col < 10'd639);
  assign vs = (row < 10'd490);

`ifdef VGA_FB_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit check_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=%0h want=%0h (row %0d col %0d, t=%0t)", name, got, want, row, col, $time);
    end
  endtask

  // Environment RAM: synchronous single port, read data one cycle after enable.
  logic [11:0] ram [0:32767];
  always @(posedge clock) begin
    if (fb.mem_en === 1'b1) begin
      if (fb.mem_we) ram[fb.mem_addr] <= fb.mem_wdata;
      else           fb.mem_rdata     <= ram[fb.mem_addr];
    end
  end

  // Reference model: a shadow framebuffer, the stored-pixel value each visible
  // position shows, and a 3-deep history of what the screen must show.
  logic [11:0] shadow [0:32767];
  bit          m_en, m_we, m_oor, m_act, m_slot;
  logic [14:0] m_addr;
  logic [11:0] m_wd, last_val;
  logic [11:0] h_pix [3];
  bit          h_hs [3];
  bit          h_vs [3];

  function automatic bit is_active(input logic [9:0] r, input logic [9:0] c);
    return (int'(c) < 640) && (int'(r) < 480);
  endfunction

  function automatic bit is_slot(input logic [9:0] r, input logic [9:0] c);
    return is_active(r, c) && (int'(c) % 4 == 0);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_en = 0; m_we = 0; m_addr = '0; m_wd = '0; m_oor = 0; last_val = '0;
      for (int i = 0; i < 3; i++) begin h_pix[i] = '0; h_hs[i] = 0; h_vs[i] = 0; end
    end else begin
      m_act  = is_active(row, col);
      m_slot = is_slot(row, col);
      if (!m_act) last_val = '0;
      if (m_slot) begin
        m_en = 1; m_we = 0;
        m_addr = 15'((int'(row) / 4) * 160 + int'(col) / 4);
        last_val = shadow[m_addr];
      end else if (fb.wr_valid) begin
        if (BOUNDS && int'(fb.wr_addr) >= 19200) begin
          m_en = 0; m_we = 0; m_oor = 1;
        end else begin
          m_en = 1; m_we = 1; m_addr = fb.wr_addr; m_wd = fb.wr_data;
          shadow[fb.wr_addr] = fb.wr_data;
        end
      end else begin
        m_en = 0; m_we = 0;
      end
      for (int i = 2; i > 0; i--) begin h_pix[i] = h_pix[i-1]; h_hs[i] = h_hs[i-1]; h_vs[i] = h_vs[i-1]; end
      h_pix[0] = m_act ? last_val : 12'h000;
      h_hs[0]  = hs;
      h_vs[0]  = vs;
    end
  end

  always @(negedge clock) begin
    if (check_on) begin
      chk("wr_ready",  32'(fb.wr_ready),  32'(!is_slot(row, col) && !reset));
      chk("mem_en",    32'(fb.mem_en),    32'(m_en));
      chk("mem_we",    32'(fb.mem_we),    32'(m_we));
      chk("mem_addr",  32'(fb.mem_addr),  32'(m_addr));
      chk("mem_wdata", 32'(fb.mem_wdata), 32'(m_wd));
      chk("pix_data",  32'(pix),          32'(h_pix[2]));
      chk("out_Hsync", 32'(out_hs),       32'(h_hs[2]));
      chk("out_Vsync", 32'(out_vs),       32'(h_vs[2]));
      chk("wr_oor",    32'(wr_oor),       32'(m_oor));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (col == 10'd799) begin
      col = '0;
      row = (row == 10'd524) ? 10'd0 : row + 10'd1;
    end else begin
      col = col + 10'd1;
    end
  endtask

  task automatic goto(input int r, input int c);
    row = 10'(r);
    col = 10'(c);
  endtask

  int  nw, nlow, nstall;
  bit  acc;

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram[i]    = 12'(i);
      shadow[i] = 12'(i);
    end
    reset = 1'b1;
    fb.wr_valid = 1'b0; fb.wr_addr = '0; fb.wr_data = '0;
    goto(10, 190);
    step();
    check_on = 1'b1;
    step();
    reset = 1'b0;

    // Mid-line reset at column 200, then first scanout read at column 204.
    while (col != 10'd200) begin @(negedge clock); step(); end
    reset = 1'b1;
    @(negedge clock);
    step();
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (col == 10'd201) begin
        chk("rst_mem_en", 32'(fb.mem_en), 32'd0);
        chk("rst_mem_addr", 32'(fb.mem_addr), 32'd0);
        chk("rst_pix", 32'(pix), 32'd0);
        chk("rst_out_hs", 32'(out_hs), 32'd0);
      end
      if (col == 10'd205) begin
        chk("first_read_en", 32'(fb.mem_en), 32'd1);
        chk("first_read_addr", 32'(fb.mem_addr), 32'd371);
      end
      step();
    end

    // Scanout of row 4: read 162 issued after column 8, shown columns 11..14.
    goto(4, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (col == 10'd9) begin
        chk("r4c8_we", 32'(fb.mem_we), 32'd0);
        chk("r4c8_addr", 32'(fb.mem_addr), 32'd162);
      end
      if (col >= 10'd11 && col <= 10'd14) chk("r4c8_pix", 32'(pix), 32'h0A2);
      if (col == 10'd15) chk("r4c12_pix", 32'(pix), 32'h0A3);
      step();
    end

    // Writer streaming through a full line.
    goto(6, 0);
    fb.wr_valid = 1'b1; fb.wr_addr = 15'd8000; fb.wr_data = 12'd0;
    nw = 0; nlow = 0; nstall = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clock);
      acc = fb.wr_valid && fb.wr_ready;
      if (col < 10'd640) begin
        if (acc) nw++;
        if (!fb.wr_ready) nlow++;
      end else if (!fb.wr_ready) begin
        nstall++;
      end
      step();
      if (acc) begin
        fb.wr_addr = fb.wr_addr + 15'd1;
        fb.wr_data = fb.wr_data + 12'd1;
      end
    end
    fb.wr_valid = 1'b0;
    chk("writes_per_line", 32'(nw), 32'd480);
    chk("ready_low_per_line", 32'(nlow), 32'd160);
    chk("blank_stalls", 32'(nstall), 32'd0);

    // Vblank write of 0xF00 to address 0, then shown at top-left next frame.
    goto(500, 100);
    fb.wr_valid = 1'b1; fb.wr_addr = 15'd0; fb.wr_data = 12'hF00;
    @(negedge clock);
    chk("vblank_ready", 32'(fb.wr_ready), 32'd1);
    step();
    fb.wr_valid = 1'b0;
    @(negedge clock);
    chk("vblank_we", 32'(fb.mem_we), 32'd1);
    chk("vblank_addr", 32'(fb.mem_addr), 32'd0);
    chk("vblank_wdata", 32'(fb.mem_wdata), 32'hF00);
    step();
    goto(0, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (col >= 10'd3 && col <= 10'd6) chk("frame_pix_f00", 32'(pix), 32'hF00);
      if (col == 10'd7) chk("frame_pix_next", 32'(pix), 32'h001);
      step();
    end
    goto(3, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (col == 10'd3) chk("row3_pix_f00", 32'(pix), 32'hF00);
      step();
    end

    // Sync alignment at the end of the active line.
    goto(7, 630);
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      if (col == 10'd641) chk("hs_before_fall", 32'(out_hs), 32'd1);
      if (col == 10'd642) begin
        chk("hs_fall_642", 32'(out_hs), 32'd0);
        chk("last_pix_642", 32'(pix), 32'h13F);
      end
      if (col == 10'd643) chk("blank_pix_643", 32'(pix), 32'd0);
      step();
    end

    // Out-of-range write address.
    goto(500, 200);
    fb.wr_valid = 1'b1; fb.wr_addr = 15'd19200; fb.wr_data = 12'hABC;
    @(negedge clock);
    chk("oor_ready", 32'(fb.wr_ready), 32'd1);
    step();
    fb.wr_valid = 1'b0;
    @(negedge clock);
`ifdef VGA_FB_BOUNDS_CHECK_EN
    chk("oor_mem_en", 32'(fb.mem_en), 32'd0);
    chk("oor_flag", 32'(wr_oor), 32'd1);
`else
    chk("oor_mem_we", 32'(fb.mem_we), 32'd1);
    chk("oor_mem_addr", 32'(fb.mem_addr), 32'd19200);
    chk("oor_flag", 32'(wr_oor), 32'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clock);
      chk("oor_sticky", 32'(wr_oor), 32'(BOUNDS));
    end
    step();

    // Count wrap 799->0 and 524->0 into the next frame.
    goto(524, 790);
    for (int k = 0; k < 24; k++) begin
      @(negedge clock);
      if (row == 10'd0 && col == 10'd1) begin
        chk("wrap_read_en", 32'(fb.mem_en), 32'd1);
        chk("wrap_read_addr", 32'(fb.mem_addr), 32'd0);
      end
      if (row == 10'd0 && col == 10'd3) chk("wrap_pix", 32'(pix), 32'hF00);
      step();
    end

    check_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
